mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised N-requestor arbiter for the single unified instruction/data memory port of the multicycle core.
- Generalises the two-way PC/result address select into a handshaked, N-channel arbiter.
- Supports byte enables, writes, round-robin or fixed priority, and a response-timeout error path.
- Sits between fetch / load-store logic and the memory; one transaction outstanding at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- N_REQ, 2, number of requestor channels (≥2).
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- TIMEOUT, 64, cycles to wait for mem_rvalid before flagging an error; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-channel request valid.
- req_ready  out  N_REQ  per-channel accept; one-hot or zero.
- req_we  in  N_REQ  per-channel write enable.
- req_addr  in  N_REQ*ADDR_W  channel i in bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed per channel.
- req_be  in  N_REQ*DATA_W/8  packed byte enables per channel.
- rsp_valid  out  N_REQ  one-cycle response strobe for the owning channel.
- rsp_rdata  out  DATA_W  shared response data.
- rsp_err  out  1  response was a timeout; qualified by any rsp_valid bit.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts the request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rvalid  in  1  memory completion (reads and writes).
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - All outputs 0.
  - Round-robin pointer = N_REQ-1, so channel 0 has first priority.
  - Timeout counter = 0.
  - Reset asserted mid-transaction aborts it; no rsp_valid is issued.
- State IDLE:
  - Winner W is the first asserted req_valid, searching from pointer+1 mod N_REQ (RR_MODE=1) or from index 0 (RR_MODE=0).
  - req_ready[W]=1 is combinational in the same cycle.
  - On that edge, latch we/addr/wdata/be/id of W, update pointer=W, and go to REQ.
  - With no valid request, stay in IDLE.
  - req_ready is 0 in every other state.
- State REQ:
  - mem_valid=1, driven from latched fields (stable while waiting).
  - On mem_ready=1, go to WAIT and clear the counter.
  - mem_rvalid in this state is ignored.
- State WAIT:
  - mem_valid=0; the counter increments each cycle.
  - On mem_rvalid=1: next cycle rsp_valid[id]=1, rsp_err=0, rsp_rdata = mem_rdata for reads or 0 for writes; go to IDLE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without mem_rvalid: next cycle rsp_valid[id]=1, rsp_err=1, rsp_rdata=0; go to IDLE.
  - If mem_rvalid arrives on the same cycle as the timeout, mem_rvalid wins (normal response).
- Response outputs:
  - rsp_valid and rsp_err are registered and last exactly one cycle.
  - rsp_rdata holds its value until the next response.
- Throughput:
  - The cycle in which rsp_valid is high is an IDLE cycle, so a new grant may occur in it.
  - Minimum latency: accept t0 → mem_valid t0+1 → (mem_ready t0+1, mem_rvalid t0+2) → rsp_valid t0+3.
- Other rules:
  - mem_rvalid arriving in IDLE (late response after timeout) is dropped.
  - Requestors must hold req_* stable until req_ready; the arbiter never deasserts a grant.
  - Id width is max(1, clog2(N_REQ)).

Test Plan:
- N_REQ=2, RR_MODE=1: both channels valid continuously, zero-wait memory → grants alternate 0,1,0,1; each rsp_valid appears 3 cycles after its req_ready.
- RR_MODE=0, N_REQ=3: channels 0 and 2 both valid → channel 0 granted every time; channel 2 granted only once channel 0 drops valid.
- Channel 1 write, addr=0x0000_0010, wdata=0xDEADBEEF, be=4'b0011; mem_ready delayed 2 cycles → mem_* stable through the wait; rsp_valid[1]=1, rsp_rdata=0, rsp_err=0.
- Read with mem_rdata=0x1234_5678 and mem_rvalid after 5 cycles in WAIT → rsp_rdata=0x1234_5678, busy high throughout, then IDLE.
- TIMEOUT=4, no mem_rvalid → rsp_err=1, rsp_rdata=0 exactly 4 cycles after entering WAIT; a late mem_rvalid in IDLE produces no rsp_valid.
- reset driven low while in WAIT → busy, mem_valid and rsp_valid are 0 immediately (asynchronous); after release, channel 0 wins the first arbitration.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding
// fetch / load-store / memory environment.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_REQ  = 2
);
    localparam int BE_W = DATA_W / 8;

    // Requestor side
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ*BE_W-1:0]   req_be;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;

    // Memory side
    logic                    mem_valid;
    logic                    mem_ready;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [BE_W-1:0]         mem_be;
    logic                    mem_rvalid;
    logic [DATA_W-1:0]       mem_rdata;

    // Status
    logic                    busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-requestor arbiter for the single unified memory port. One transaction
// is outstanding at a time: IDLE grants, REQ presents the latched request
// until the memory accepts it, WAIT collects the completion or times out.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_REQ   = 2,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  rsp_rdata_q;

    logic               win_vld_d;
    logic [ID_W-1:0]    win_id_d;

    // Pick the first valid channel after the last winner (round-robin) or
    // from channel 0 (fixed priority, start just "after" N_REQ-1).
    always_comb begin
        int start;
        logic [ID_W-1:0] cidx;
        win_vld_d = 1'b0;
        win_id_d  = '0;
        cidx      = '0;
        start     = (RR_MODE != 0) ? int'(ptr_q) : N_REQ - 1;
        for (int k = 1; k <= N_REQ; k++) begin
            cidx = ID_W'((start + k) % N_REQ);
            if (!win_vld_d && bus.req_valid[cidx]) begin
                win_vld_d = 1'b1;
                win_id_d  = cidx;
            end
        end
    end

    // Grant is combinational in IDLE only; held off while reset is asserted.
    always_comb begin
        bus.req_ready = '0;
        if (reset && (state_q == IDLE) && win_vld_d) begin
            bus.req_ready = ONE_HOT0 << win_id_d;
        end
    end

    assign bus.mem_valid = (state_q == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = (state_q != IDLE);

    // Transaction FSM: latch winner, hand to memory, collect completion.
    // Response strobes default low so they last exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        id_q    <= win_id_d;
                        ptr_q   <= win_id_d;
                        we_q    <= bus.req_we[win_id_d];
                        addr_q  <= bus.req_addr[win_id_d*ADDR_W +: ADDR_W];
                        wdata_q <= bus.req_wdata[win_id_d*DATA_W +: DATA_W];
                        be_q    <= bus.req_be[win_id_d*BE_W +: BE_W];
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A completion on the timeout cycle still counts as normal.
                    if (bus.mem_rvalid) begin
                        rsp_valid_q <= ONE_HOT0 << id_q;
                        rsp_rdata_q <= we_q ? '0 : bus.mem_rdata;
                        state_q     <= IDLE;
                    end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                        rsp_valid_q <= ONE_HOT0 << id_q;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (2-channel round-robin with
// TIMEOUT=8, 3-channel fixed priority with TIMEOUT=4) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .N_REQ(2)) ifa ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .N_REQ(3)) ifb ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .N_REQ(2), .RR_MODE(1), .TIMEOUT(8))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .N_REQ(3), .RR_MODE(0), .TIMEOUT(4))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    // Model: ph 0 = free, 1 = request offered to memory, 2 = awaiting completion
    typedef struct packed {
        int          ph;
        int          last;
        int          own;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waited;
        logic        rv;
        int          rid;
        logic        rerr;
        logic [31:0] rdata;
    } mdl_t;

    mdl_t ma, mb;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycle = 0;
    bit   auto_a = 0, auto_b = 0;
    bit   fire_a, fire_b;
    int   ga_ch[$], ga_cyc[$], ra_ch[$], ra_cyc[$], gb_ch[$];

    function automatic mdl_t mreset(int n);
        mdl_t r;
        r = '0;
        r.last = n - 1;
        return r;
    endfunction

    function automatic int pick(logic [2:0] v, int n, bit rr, int last);
        int start;
        start = rr ? last : n - 1;
        for (int k = 1; k <= n; k++) begin
            if (v[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    function automatic int oh2i(logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int n, bit rr, int to, logic [2:0] v, logic [2:0] we,
                                   logic [95:0] addr, logic [95:0] wdata, logic [11:0] be,
                                   logic mready, logic mrvalid, logic [31:0] mrdata);
        mdl_t r;
        int w;
        r = s;
        r.rv = 1'b0;
        r.rerr = 1'b0;
        if (s.ph == 0) begin
            w = pick(v, n, rr, s.last);
            if (w >= 0) begin
                r.own = w; r.last = w; r.we = we[w];
                r.addr = addr[w*32 +: 32]; r.wdata = wdata[w*32 +: 32]; r.be = be[w*4 +: 4];
                r.ph = 1;
            end
        end else if (s.ph == 1) begin
            if (mready) begin r.ph = 2; r.waited = 0; end
        end else begin
            if (mrvalid) begin
                r.rv = 1'b1; r.rid = s.own; r.rdata = s.we ? 32'h0 : mrdata; r.ph = 0;
            end else if (to != 0 && s.waited + 1 == to) begin
                r.rv = 1'b1; r.rid = s.own; r.rerr = 1'b1; r.rdata = 32'h0; r.ph = 0;
            end else begin
                r.waited = s.waited + 1;
            end
        end
        return r;
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    task automatic chk_dut(string t, mdl_t s, int n, bit rr, logic [2:0] v, logic [2:0] rdy,
                           logic [2:0] rv, logic err, logic [31:0] rd, logic mv, logic mwe,
                           logic [31:0] mad, logic [31:0] mwd, logic [3:0] mbe, logic bsy);
        int w;
        logic [2:0] er, ev;
        w  = pick(v, n, rr, s.last);
        er = (s.ph == 0 && reset && w >= 0) ? (3'b001 << w) : 3'b000;
        ev = s.rv ? (3'b001 << s.rid) : 3'b000;
        cmp({t, ".req_ready"}, 32'(rdy), 32'(er));
        cmp({t, ".rsp_valid"}, 32'(rv), 32'(ev));
        cmp({t, ".rsp_err"}, 32'(err), 32'(s.rerr));
        cmp({t, ".rsp_rdata"}, rd, s.rdata);
        cmp({t, ".mem_valid"}, 32'(mv), 32'(s.ph == 1));
        cmp({t, ".busy"}, 32'(bsy), 32'(s.ph != 0));
        if (s.ph == 1) begin
            cmp({t, ".mem_we"}, 32'(mwe), 32'(s.we));
            cmp({t, ".mem_addr"}, mad, s.addr);
            cmp({t, ".mem_wdata"}, mwd, s.wdata);
            cmp({t, ".mem_be"}, 32'(mbe), 32'(s.be));
        end
    endtask

    // One clock: compare at negedge, log grants/responses, advance model at posedge
    task automatic cyc();
        @(negedge clk);
        chk_dut("A", ma, 2, 1'b1, {1'b0, ifa.req_valid}, {1'b0, ifa.req_ready}, {1'b0, ifa.rsp_valid},
                ifa.rsp_err, ifa.rsp_rdata, ifa.mem_valid, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata,
                ifa.mem_be, ifa.busy);
        chk_dut("B", mb, 3, 1'b0, ifb.req_valid, ifb.req_ready, ifb.rsp_valid,
                ifb.rsp_err, ifb.rsp_rdata, ifb.mem_valid, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata,
                ifb.mem_be, ifb.busy);
        if (ifa.req_ready != 0) begin ga_ch.push_back(oh2i({1'b0, ifa.req_ready})); ga_cyc.push_back(cycle); end
        if (ifa.rsp_valid != 0) begin ra_ch.push_back(oh2i({1'b0, ifa.rsp_valid})); ra_cyc.push_back(cycle); end
        if (ifb.req_ready != 0) gb_ch.push_back(oh2i(ifb.req_ready));
        fire_a = ifa.mem_valid && ifa.mem_ready;
        fire_b = ifb.mem_valid && ifb.mem_ready;
        @(posedge clk);
        if (reset) begin
            ma = mstep(ma, 2, 1'b1, 8, {1'b0, ifa.req_valid}, {1'b0, ifa.req_we}, {32'h0, ifa.req_addr},
                       {32'h0, ifa.req_wdata}, {4'h0, ifa.req_be}, ifa.mem_ready, ifa.mem_rvalid, ifa.mem_rdata);
            mb = mstep(mb, 3, 1'b0, 4, ifb.req_valid, ifb.req_we, ifb.req_addr, ifb.req_wdata, ifb.req_be,
                       ifb.mem_ready, ifb.mem_rvalid, ifb.mem_rdata);
        end
        cycle++;
        #1;
        if (auto_a) begin ifa.mem_ready = 1'b1; ifa.mem_rvalid = fire_a; ifa.mem_rdata = 32'hA500_0000 + cycle; end
        if (auto_b) begin ifb.mem_ready = 1'b1; ifb.mem_rvalid = fire_b; ifb.mem_rdata = 32'hB500_0000 + cycle; end
    endtask

    initial begin
        reset = 1'b0;
        ifa.req_valid = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_wdata = '0; ifa.req_be = '0;
        ifa.mem_ready = 1'b0; ifa.mem_rvalid = 1'b0; ifa.mem_rdata = '0;
        ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_wdata = '0; ifb.req_be = '0;
        ifb.mem_ready = 1'b0; ifb.mem_rvalid = 1'b0; ifb.mem_rdata = '0;
        ma = mreset(2);
        mb = mreset(3);
        #3;
        cmp("reset.busy", 32'(ifa.busy), 32'd0);
        cmp("reset.mem_valid", 32'(ifa.mem_valid), 32'd0);
        cmp("reset.rsp_valid", 32'(ifb.rsp_valid), 32'd0);
        cmp("reset.rsp_rdata", ifb.rsp_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) cyc();

        // Round-robin, both channels always valid, zero-wait memory
        ifa.req_addr = {32'h0000_0104, 32'h0000_0100};
        ifa.req_be   = 8'hFF;
        ifa.req_valid = 2'b11;
        auto_a = 1;
        ga_ch.delete(); ga_cyc.delete(); ra_ch.delete(); ra_cyc.delete();
        repeat (13) cyc();
        ifa.req_valid = 2'b00;
        repeat (4) cyc();
        auto_a = 0; ifa.mem_ready = 1'b0; ifa.mem_rvalid = 1'b0;
        if (ga_ch.size() >= 4 && ra_ch.size() >= 4) begin
            cmp("rr.grant0", 32'(ga_ch[0]), 32'd0);
            cmp("rr.grant1", 32'(ga_ch[1]), 32'd1);
            cmp("rr.grant2", 32'(ga_ch[2]), 32'd0);
            cmp("rr.grant3", 32'(ga_ch[3]), 32'd1);
            for (int i = 0; i < 4; i++) begin
                cmp("rr.rsp_ch", 32'(ra_ch[i]), 32'(ga_ch[i]));
                cmp("rr.rsp_latency", 32'(ra_cyc[i] - ga_cyc[i]), 32'd3);
            end
        end else begin
            cmp("rr.count", 32'(ga_ch.size() * 16 + ra_ch.size()), 32'h44);
        end

        // Fixed priority on 3 channels: 0 beats 2 until 0 drops
        ifb.req_addr = {32'h0000_0208, 32'h0, 32'h0000_0200};
        ifb.req_valid = 3'b101;
        auto_b = 1;
        gb_ch.delete();
        for (int i = 0; i < 30 && gb_ch.size() < 3; i++) cyc();
        ifb.req_valid[0] = 1'b0;
        for (int i = 0; i < 30 && gb_ch.size() < 4; i++) cyc();
        ifb.req_valid = 3'b000;
        repeat (4) cyc();
        auto_b = 0; ifb.mem_ready = 1'b0; ifb.mem_rvalid = 1'b0;
        if (gb_ch.size() == 4) begin
            cmp("fp.grant0", 32'(gb_ch[0]), 32'd0);
            cmp("fp.grant1", 32'(gb_ch[1]), 32'd0);
            cmp("fp.grant2", 32'(gb_ch[2]), 32'd0);
            cmp("fp.grant3", 32'(gb_ch[3]), 32'd2);
        end else begin
            cmp("fp.count", 32'(gb_ch.size()), 32'd4);
        end

        // Channel 1 write with memory accept delayed two cycles
        ifa.req_we    = 2'b10;
        ifa.req_addr  = {32'h0000_0010, 32'h0};
        ifa.req_wdata = {32'hDEAD_BEEF, 32'h0};
        ifa.req_be    = {4'b0011, 4'b0000};
        ifa.req_valid = 2'b10;
        #1 cmp("wr.req_ready", 32'(ifa.req_ready), 32'h2);
        cyc();
        ifa.req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp("wr.mem_valid", 32'(ifa.mem_valid), 32'd1);
            cmp("wr.mem_we", 32'(ifa.mem_we), 32'd1);
            cmp("wr.mem_addr", ifa.mem_addr, 32'h0000_0010);
            cmp("wr.mem_wdata", ifa.mem_wdata, 32'hDEAD_BEEF);
            cmp("wr.mem_be", 32'(ifa.mem_be), 32'h3);
            if (i == 2) ifa.mem_ready = 1'b1;
            cyc();
        end
        ifa.mem_ready = 1'b0;
        #1 cmp("wr.wait_mem_valid", 32'(ifa.mem_valid), 32'd0);
        ifa.mem_rvalid = 1'b1; ifa.mem_rdata = 32'hFFFF_FFFF;
        cyc();
        ifa.mem_rvalid = 1'b0;
        #1;
        cmp("wr.rsp_valid", 32'(ifa.rsp_valid), 32'h2);
        cmp("wr.rsp_rdata", ifa.rsp_rdata, 32'h0);
        cmp("wr.rsp_err", 32'(ifa.rsp_err), 32'd0);
        cmp("wr.busy_after", 32'(ifa.busy), 32'd0);

        // Channel 0 read, completion after five WAIT cycles
        ifa.req_we = 2'b00; ifa.req_addr = {32'h0, 32'h0000_0020}; ifa.req_be = 8'h0F;
        ifa.req_valid = 2'b01;
        cyc();
        ifa.req_valid = 2'b00; ifa.mem_ready = 1'b1;
        cyc();
        ifa.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 cmp("rd.busy", 32'(ifa.busy), 32'd1);
            cyc();
        end
        ifa.mem_rvalid = 1'b1; ifa.mem_rdata = 32'h1234_5678;
        cyc();
        ifa.mem_rvalid = 1'b0;
        #1;
        cmp("rd.rsp_valid", 32'(ifa.rsp_valid), 32'h1);
        cmp("rd.rsp_rdata", ifa.rsp_rdata, 32'h1234_5678);
        cmp("rd.rsp_err", 32'(ifa.rsp_err), 32'd0);
        cmp("rd.busy_after", 32'(ifa.busy), 32'd0);
        cyc();
        #1;
        cmp("rd.rsp_one_cycle", 32'(ifa.rsp_valid), 32'h0);
        cmp("rd.rdata_hold", ifa.rsp_rdata, 32'h1234_5678);

        // Timeout on instance B (TIMEOUT=4), then a late completion in IDLE
        ifb.req_addr = {32'h0, 32'h0000_0030, 32'h0};
        ifb.req_valid = 3'b010;
        cyc();
        ifb.req_valid = 3'b000; ifb.mem_ready = 1'b1;
        cyc();
        ifb.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1 cmp("to.no_rsp_yet", 32'(ifb.rsp_valid), 32'h0);
        end
        cyc();
        #1;
        cmp("to.rsp_valid", 32'(ifb.rsp_valid), 32'h2);
        cmp("to.rsp_err", 32'(ifb.rsp_err), 32'd1);
        cmp("to.rsp_rdata", ifb.rsp_rdata, 32'h0);
        ifb.mem_rvalid = 1'b1; ifb.mem_rdata = 32'h0000_CAFE;
        cyc();
        ifb.mem_rvalid = 1'b0;
        #1;
        cmp("late.rsp_valid", 32'(ifb.rsp_valid), 32'h0);
        cmp("late.rsp_rdata", ifb.rsp_rdata, 32'h0);
        cmp("late.busy", 32'(ifb.busy), 32'd0);

        // Reset during WAIT aborts; channel 0 wins afterwards
        ifa.req_valid = 2'b01;
        cyc();
        ifa.req_valid = 2'b00; ifa.mem_ready = 1'b1;
        cyc();
        ifa.mem_ready = 1'b0;
        cyc();
        #2;
        reset = 1'b0;
        ma = mreset(2);
        mb = mreset(3);
        #1;
        cmp("arst.busy", 32'(ifa.busy), 32'd0);
        cmp("arst.mem_valid", 32'(ifa.mem_valid), 32'd0);
        cmp("arst.rsp_valid", 32'(ifa.rsp_valid), 32'h0);
        repeat (2) cyc();
        reset = 1'b1;
        ifa.req_addr = {32'h0000_0044, 32'h0000_0040};
        ifa.req_valid = 2'b11;
        #1 cmp("arst.first_grant", 32'(ifa.req_ready), 32'h1);
        cyc();
        ifa.req_valid = 2'b00; ifa.mem_ready = 1'b1;
        cyc();
        ifa.mem_ready = 1'b0; ifa.mem_rvalid = 1'b1; ifa.mem_rdata = 32'h0BAD_F00D;
        cyc();
        ifa.mem_rvalid = 1'b0;
        #1 cmp("arst.rsp_valid_after", 32'(ifa.rsp_valid), 32'h1);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
